gpr_dbg_access: RTL and testbench

- Debug-side initiator for the general-purpose register file: accepts abstract read/write commands from the debug transport.
- Halts the core, then performs a single-cycle access on the register file's write port or one read port, and returns a response.
- Sits between the debug module and the core's GPR write/read mux, which grants it the ports while halt_req_o is high.

---
 rtl/gpr_dbg_access.sv | 132 +++++++++++++
 tb/tb_gpr_dbg_access.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_dbg_access.sv
// Debug-side GPR access engine: halts the core, performs one register read or write, returns a response.
// Optional build macro GPR_DBG_KEEP_HALT_EN adds cmd_keep_halt_i to keep the core halted between commands.
module gpr_dbg_access #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
`ifdef GPR_DBG_KEEP_HALT_EN
    input  logic        cmd_keep_halt_i,
`endif
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        halt_req_o,
    input  logic        halted_i,
    output logic        gpr_we_o,
    output logic [4:0]  gpr_waddr_o,
    output logic [31:0] gpr_wdata_o,
    output logic [4:0]  gpr_raddr_o,
    input  logic [31:0] gpr_rdata_i,
    output logic [1:0]  dbg_state
);

    // Handshakes: a command transfers on a cycle where cmd_valid_i & cmd_ready_o,
    // a response on a cycle where rsp_valid_o & rsp_ready_i; valid never drops before its transfer.

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HALT_WAIT = 2'd1;
    localparam logic [1:0] ACCESS    = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam bit          TIMEOUT_EN = (HALT_TIMEOUT != 0);
    localparam logic [15:0] CNT_LAST   = TIMEOUT_EN ? 16'(HALT_TIMEOUT - 1) : 16'd0;

    logic [1:0]  state_q;
    logic        write_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        do_write;

`ifdef GPR_DBG_KEEP_HALT_EN
    logic keep_q;
    logic hold_q;
`endif

    // Writes to x0 are dropped here so the register file never sees a strobe for them.
    assign do_write = (state_q == ACCESS) && write_q && (addr_q != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef GPR_DBG_KEEP_HALT_EN
            keep_q  <= 1'b0;
            hold_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        write_q <= cmd_write_i;
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        cnt_q   <= 16'd0;
`ifdef GPR_DBG_KEEP_HALT_EN
                        keep_q  <= cmd_keep_halt_i;
`endif
                        state_q <= HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    if (halted_i) begin
                        state_q <= ACCESS;
                    end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ACCESS: begin
                    rdata_q <= write_q ? 32'd0 : gpr_rdata_i;
                    err_q   <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b0;
`ifdef GPR_DBG_KEEP_HALT_EN
                        hold_q  <= keep_q;
`endif
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign gpr_we_o    = do_write;
    assign gpr_waddr_o = do_write ? addr_q : 5'd0;
    assign gpr_wdata_o = do_write ? wdata_q : 32'd0;
    assign gpr_raddr_o = (state_q == ACCESS) ? addr_q : 5'd0;
    assign dbg_state   = state_q;

`ifdef GPR_DBG_KEEP_HALT_EN
    assign halt_req_o = (state_q != IDLE) || hold_q;
`else
    assign halt_req_o = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_gpr_dbg_access.sv
// Bench for gpr_dbg_access: directed scenarios plus randomized commands against a register-file reference model.
module tb_gpr_dbg_access;

    localparam int TIMEOUT = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [4:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        halt_req_o;
    logic        halted_i;
    logic        gpr_we_o;
    logic [4:0]  gpr_waddr_o;
    logic [31:0] gpr_wdata_o;
    logic [4:0]  gpr_raddr_o;
    logic [31:0] gpr_rdata_i;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int errors  = 0;
    int we_count = 0;
    int exp_we   = 0;

    logic [31:0] gpr_mem [32];
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    gpr_dbg_access #(.HALT_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
`ifdef GPR_DBG_KEEP_HALT_EN
        .cmd_keep_halt_i (1'b0),
`endif
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .halt_req_o  (halt_req_o),
        .halted_i    (halted_i),
        .gpr_we_o    (gpr_we_o),
        .gpr_waddr_o (gpr_waddr_o),
        .gpr_wdata_o (gpr_wdata_o),
        .gpr_raddr_o (gpr_raddr_o),
        .gpr_rdata_i (gpr_rdata_i),
        .dbg_state   (dbg_state)
    );

    // Core register file stand-in: x0 reads as zero, cleared with the core on reset.
    assign gpr_rdata_i = gpr_mem[gpr_raddr_o];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) gpr_mem[i] <= 32'd0;
        end else if (gpr_we_o && gpr_waddr_o != 5'd0) begin
            gpr_mem[gpr_waddr_o] <= gpr_wdata_o;
        end
        if (gpr_we_o) we_count <= we_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, ".halt_req"},  32'(halt_req_o),  32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ".rsp_rdata"}, rsp_rdata_o,      32'd0);
        chk({tag, ".rsp_err"},   32'(rsp_err_o),   32'd0);
        chk({tag, ".gpr_we"},    32'(gpr_we_o),    32'd0);
        chk({tag, ".gpr_waddr"}, 32'(gpr_waddr_o), 32'd0);
        chk({tag, ".gpr_wdata"}, gpr_wdata_o,      32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = 5'd0; cmd_wdata_i = 32'd0;
        rsp_ready_i = 1'b0; halted_i = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        repeat (cycles) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
    endtask

    // One command end to end. delay = cycles of HALT_WAIT before halted_i rises; stall = extra RESP cycles.
    task automatic do_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                          input int delay, input int stall);
        bit          timeout;
        int          hw;
        logic [31:0] exp_rd;
        timeout = (TIMEOUT != 0) && (delay >= TIMEOUT);
        hw      = timeout ? TIMEOUT : delay + 1;
        exp_rd  = 32'd0;

        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd;
        halted_i = 1'b0; rsp_ready_i = 1'b0;
        chk("accept.cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk);

        for (int i = 0; i < hw; i++) begin
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_write_i = 1'($urandom_range(0, 1));
            cmd_addr_i  = 5'($urandom_range(0, 31));
            halted_i    = !timeout && (i == delay);
            chk("wait.halt_req",  32'(halt_req_o),  32'd1);
            chk("wait.cmd_ready", 32'(cmd_ready_o), 32'd0);
            chk("wait.rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("wait.gpr_we",    32'(gpr_we_o),    32'd0);
            @(negedge clk);
        end

        if (!timeout) begin
            halted_i = 1'($urandom_range(0, 1));
            chk("access.halt_req",  32'(halt_req_o),  32'd1);
            chk("access.rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("access.gpr_raddr", 32'(gpr_raddr_o), 32'(addr));
            if (wr && addr != 5'd0) begin
                chk("access.gpr_we",    32'(gpr_we_o),    32'd1);
                chk("access.gpr_waddr", 32'(gpr_waddr_o), 32'(addr));
                chk("access.gpr_wdata", gpr_wdata_o,      wd);
                ref_regs[addr] = wd;
                exp_we++;
            end else begin
                chk("access.gpr_we", 32'(gpr_we_o), 32'd0);
            end
            if (!wr) exp_rd = ref_regs[addr];
            @(negedge clk);
        end

        for (int s = 0; s <= stall; s++) begin
            rsp_ready_i = (s == stall);
            halted_i    = 1'($urandom_range(0, 1));
            cmd_valid_i = 1'($urandom_range(0, 1));
            chk("resp.rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("resp.rsp_err",   32'(rsp_err_o),   32'(timeout));
            chk("resp.rsp_rdata", rsp_rdata_o,      exp_rd);
            chk("resp.halt_req",  32'(halt_req_o),  32'd1);
            chk("resp.cmd_ready", 32'(cmd_ready_o), 32'd0);
            chk("resp.gpr_we",    32'(gpr_we_o),    32'd0);
            @(negedge clk);
        end

        cmd_valid_i = 1'b0; rsp_ready_i = 1'b0; halted_i = 1'b0;
        chk_idle("after");
    endtask

    initial begin
        @(negedge clk);
        apply_reset(2);

        // Directed scenarios
        do_cmd(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 0);
        do_cmd(1'b0, 5'd5, 32'h0, 0, 0);
        do_cmd(1'b1, 5'd9, 32'hCAFE_0009, 10, 0);
        do_cmd(1'b0, 5'd9, 32'h0, 10, 1);
        do_cmd(1'b1, 5'd7, 32'h7777_7777, 1000, 0);
        do_cmd(1'b0, 5'd7, 32'h0, 0, 0);
        do_cmd(1'b1, 5'd0, 32'h0000_1234, 0, 5);
        do_cmd(1'b0, 5'd0, 32'h0, 0, 2);
        do_cmd(1'b1, 5'd31, 32'hFFFF_FFFF, TIMEOUT - 1, 0);
        do_cmd(1'b0, 5'd31, 32'h0, 0, 0);

        // Reset during HALT_WAIT of a write: nothing may be written
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 5'd3; cmd_wdata_i = 32'h3333_3333;
        halted_i = 1'b0;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset.halt_req", 32'(halt_req_o), 32'd1);
        halted_i = 1'b1;
        apply_reset(1);
        halted_i = 1'b0;
        @(negedge clk);
        chk_idle("midreset.idle");
        do_cmd(1'b0, 5'd3, 32'h0, 0, 0);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            logic        wr;
            logic [4:0]  addr;
            int          gap;
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_cmd(wr, addr, $urandom, $urandom_range(0, TIMEOUT + 3), $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk_idle("gap");
            end
        end

        chk("total.gpr_we_pulses", 32'(we_count), 32'(exp_we));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
